// File: rtl/asteroids_pkg.sv
// Shared entity-word layout, shot constants and sweep FSM state type for the
// asteroids object tables.
package asteroids_pkg;

  localparam int ACTIVE_BIT = 33;
  localparam int LIFE_MSB   = 32;
  localparam int LIFE_LSB   = 30;
  localparam int HEAD_MSB   = 28;
  localparam int HEAD_LSB   = 26;
  localparam int Y_MSB      = 25;
  localparam int Y_LSB      = 16;
  localparam int X_MSB      = 15;
  localparam int X_LSB      = 6;
  localparam int SPRITE_MSB = 5;
  localparam int SPRITE_LSB = 0;

  localparam logic [5:0] SPRITE_SHOT = 6'd2;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef logic [2:0] heading_t;
  typedef logic [9:0] screen_coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } sweep_state_t;

  // Bit 29 is reserved and always written as zero.
  function automatic logic [33:0] make_shot(input screen_coord_t x,
                                            input screen_coord_t y,
                                            input heading_t      heading,
                                            input logic [2:0]    life);
    return {1'b1, life, 1'b0, heading, y, x, SPRITE_SHOT};
  endfunction

endpackage

// File: rtl/shot_table_if.sv
// Spawn and delete request bundle between the ship/fire logic, the collision
// controller and the shot table.
interface shot_table_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [2:0] spawn_heading;
  logic       delete_shot;
  logic [9:0] shot_address;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_heading, delete_shot, shot_address,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_heading, delete_shot, shot_address,
    output spawn_ready
  );
endinterface

// File: rtl/shot_velocity_lut.sv
// Heading to per-frame velocity: cardinals move SHOT_SPEED on one axis,
// diagonals move SHOT_SPEED-1 on both axes. Headings run clockwise from N.
module shot_velocity_lut #(
  parameter int SHOT_SPEED = 4
) (
  input  logic [2:0]        heading_i,
  output logic signed [9:0] vx_o,
  output logic signed [9:0] vy_o
);
  localparam logic signed [9:0] S = 10'(SHOT_SPEED);
  localparam logic signed [9:0] D = 10'(SHOT_SPEED - 1);

  always_comb begin
    vx_o = '0;
    vy_o = '0;
    case (heading_i)
      3'd0: begin vx_o = '0; vy_o = -S; end
      3'd1: begin vx_o =  D; vy_o = -D; end
      3'd2: begin vx_o =  S; vy_o = '0; end
      3'd3: begin vx_o =  D; vy_o =  D; end
      3'd4: begin vx_o = '0; vy_o =  S; end
      3'd5: begin vx_o = -D; vy_o =  D; end
      3'd6: begin vx_o = -S; vy_o = '0; end
      default: begin vx_o = -D; vy_o = -D; end
    endcase
  end
endmodule

// File: rtl/shot_table.sv
// Player shot storage: spawns into the lowest free slot, moves every active
// shot once per frame_tick sweep, and clears slots on delete_shot.
// Optional macro SHOT_LIFETIME_EN: shots auto-expire after SHOT_LIFETIME sweeps.
module shot_table
  import asteroids_pkg::*;
#(
  parameter int MAX_SHOTS     = 3,
  parameter int ENTITY_SIZE   = 34,
  parameter int SHOT_SPEED    = 4,
  parameter int SHOT_LIFETIME = 6
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 frame_tick,
  shot_table_if.slave                          bus,
  output logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots,
  output logic [$clog2(MAX_SHOTS+1)-1:0]       active_count,
  output logic                                 update_done,
  output logic                                 overrun
);
  localparam int IDX_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
  localparam int CNT_W = $clog2(MAX_SHOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SHOTS - 1);

  sweep_state_t           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ENTITY_SIZE-1:0] slot_q [MAX_SHOTS];
  logic [ENTITY_SIZE-1:0] slot_d [MAX_SHOTS];
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   overrun_q, overrun_d;

  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic                   spawn_fire;
  logic                   del_hit;
  logic [ENTITY_SIZE-1:0] cur_word, upd_word;
  logic signed [9:0]      vx, vy;

  // Held low during reset so nothing upstream sees a ready before release.
  assign bus.spawn_ready = reset_n && (state_q == ST_IDLE) && free_found;
  assign spawn_fire      = bus.spawn_valid && bus.spawn_ready;
  assign del_hit         = bus.delete_shot && (bus.shot_address < 10'(MAX_SHOTS));

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
      if (!slot_q[i][ACTIVE_BIT]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < MAX_SHOTS; i++) begin
      if (idx_q == IDX_W'(i)) cur_word = slot_q[i];
    end
  end

  shot_velocity_lut #(.SHOT_SPEED(SHOT_SPEED)) u_vel (
    .heading_i (cur_word[HEAD_MSB:HEAD_LSB]),
    .vx_o      (vx),
    .vy_o      (vy)
  );

  // Plain 10-bit wraparound; off-screen results are culled downstream.
  always_comb begin
    upd_word = cur_word;
    upd_word[X_MSB:X_LSB] = cur_word[X_MSB:X_LSB] + $unsigned(vx);
    upd_word[Y_MSB:Y_LSB] = cur_word[Y_MSB:Y_LSB] + $unsigned(vy);
`ifdef SHOT_LIFETIME_EN
    if (cur_word[LIFE_MSB:LIFE_LSB] == 3'd1) begin
      upd_word = '0;
    end else begin
      upd_word[LIFE_MSB:LIFE_LSB] = cur_word[LIFE_MSB:LIFE_LSB] - 3'd1;
    end
`endif
    if (!cur_word[ACTIVE_BIT]) upd_word = cur_word;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    overrun_d = overrun_q | (frame_tick && (state_q != ST_IDLE));
    cnt_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Per-slot priority: delete over sweep update over spawn.
    for (int i = 0; i < MAX_SHOTS; i++) begin
      if (spawn_fire && (free_idx == IDX_W'(i))) begin
        slot_d[i] = ENTITY_SIZE'(make_shot(bus.spawn_x, bus.spawn_y,
                                           bus.spawn_heading, 3'(SHOT_LIFETIME)));
      end
      if ((state_q == ST_UPDATE) && (idx_q == IDX_W'(i))) slot_d[i] = upd_word;
      if (del_hit && (bus.shot_address == 10'(i)))        slot_d[i] = '0;
    end

    for (int i = 0; i < MAX_SHOTS; i++) begin
      cnt_d = cnt_d + CNT_W'(slot_d[i][ACTIVE_BIT]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < MAX_SHOTS; i++) slot_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < MAX_SHOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  for (genvar g = 0; g < MAX_SHOTS; g++) begin : g_pack
    assign shots[g*ENTITY_SIZE +: ENTITY_SIZE] = slot_q[g];
  end

  assign active_count = cnt_q;
  assign update_done  = (state_q == ST_DONE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_shot_table.sv
// Directed bench for shot_table: spawn, delete, sweep motion, overrun, reset
// abort and lifetime behaviour (follows SHOT_LIFETIME_EN when defined).
module tb_shot_table;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [101:0] shots;
  logic [1:0]  active_count;
  logic        update_done;
  logic        overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  shot_table_if bus ();

  shot_table #(.MAX_SHOTS(3), .ENTITY_SIZE(34), .SHOT_SPEED(4), .SHOT_LIFETIME(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .bus          (bus),
    .shots        (shots),
    .active_count (active_count),
    .update_done  (update_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] slot(input int i);
    return shots[i*34 +: 34];
  endfunction

  function automatic logic [33:0] exp_word(input logic [2:0] life, input logic [2:0] h,
                                           input logic [9:0] y, input logic [9:0] x);
    return {1'b1, life, 1'b0, h, y, x, 6'd2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_tick        = 1'b0;
    bus.spawn_valid   = 1'b0;
    bus.spawn_x       = '0;
    bus.spawn_y       = '0;
    bus.spawn_heading = '0;
    bus.delete_shot   = 1'b0;
    bus.shot_address  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic spawn(input logic [9:0] x, input logic [9:0] y, input logic [2:0] h);
    bus.spawn_valid   = 1'b1;
    bus.spawn_x       = x;
    bus.spawn_y       = y;
    bus.spawn_heading = h;
    tick();
    bus.spawn_valid   = 1'b0;
  endtask

  // Starts a sweep and returns the tick-to-done latency in cycles (0 = timeout).
  task automatic run_sweep(output int lat);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    lat = 1;
    while (!update_done && lat < 20) begin
      tick();
      lat++;
    end
    if (!update_done) lat = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (shots !== '0) begin tests_failed++; $display("FAIL reset_shots got=%h exp=0", shots); end
    tests_run++;
    if ({bus.spawn_ready, update_done, overrun, active_count} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outs got rdy=%b done=%b ovr=%b cnt=%0d exp all 0",
               bus.spawn_ready, update_done, overrun, active_count);
    end
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (bus.spawn_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset got=%b exp=1", bus.spawn_ready); end
  endtask

  task automatic test_spawn();
    do_reset();
    spawn(10'd100, 10'd50, 3'd2);
    tests_run++;
    if (slot(0) !== exp_word(3'd6, 3'd2, 10'd50, 10'd100)) begin
      tests_failed++;
      $display("FAIL spawn_word got=%h exp=%h", slot(0), exp_word(3'd6, 3'd2, 10'd50, 10'd100));
    end
    tests_run++;
    if (bus.spawn_ready !== 1'b1 || active_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL spawn_status got rdy=%b cnt=%0d exp rdy=1 cnt=1", bus.spawn_ready, active_count);
    end
  endtask

  task automatic test_fill_delete();
    do_reset();
    spawn(10'd1, 10'd2, 3'd0);
    spawn(10'd3, 10'd4, 3'd4);
    spawn(10'd5, 10'd6, 3'd6);
    tests_run++;
    if (bus.spawn_ready !== 1'b0 || active_count !== 2'd3) begin
      tests_failed++;
      $display("FAIL full_status got rdy=%b cnt=%0d exp rdy=0 cnt=3", bus.spawn_ready, active_count);
    end
    spawn(10'd7, 10'd8, 3'd2);
    tests_run++;
    if (slot(2) !== exp_word(3'd6, 3'd6, 10'd6, 10'd5) || slot(0) !== exp_word(3'd6, 3'd0, 10'd2, 10'd1)) begin
      tests_failed++;
      $display("FAIL full_no_write got s0=%h s2=%h", slot(0), slot(2));
    end
    bus.delete_shot  = 1'b1;
    bus.shot_address = 10'd5;
    tick();
    tests_run++;
    if (active_count !== 2'd3) begin tests_failed++; $display("FAIL del_out_of_range got cnt=%0d exp=3", active_count); end
    bus.shot_address = 10'd1;
    tick();
    bus.delete_shot  = 1'b0;
    tests_run++;
    if (slot(1) !== '0 || bus.spawn_ready !== 1'b1 || active_count !== 2'd2) begin
      tests_failed++;
      $display("FAIL del_slot1 got s1=%h rdy=%b cnt=%0d exp s1=0 rdy=1 cnt=2", slot(1), bus.spawn_ready, active_count);
    end
    spawn(10'd200, 10'd100, 3'd4);
    tests_run++;
    if (slot(1) !== exp_word(3'd6, 3'd4, 10'd100, 10'd200) || active_count !== 2'd3) begin
      tests_failed++;
      $display("FAIL respawn_slot1 got s1=%h cnt=%0d", slot(1), active_count);
    end
  endtask

  task automatic test_motion();
    int lat;
    logic [2:0] exp_life;
`ifdef SHOT_LIFETIME_EN
    exp_life = 3'd5;
`else
    exp_life = 3'd6;
`endif
    do_reset();
    spawn(10'd2, 10'd10, 3'd6);
    spawn(10'd10, 10'd10, 3'd1);
    // Third shot spawned in the same cycle as frame_tick must be moved too.
    bus.spawn_valid   = 1'b1;
    bus.spawn_x       = 10'd50;
    bus.spawn_y       = 10'd60;
    bus.spawn_heading = 3'd3;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    bus.spawn_valid = 1'b0;
    lat = 1;
    while (!update_done && lat < 20) begin tick(); lat++; end
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL sweep_latency got=%0d exp=4", lat); end
    tests_run++;
    if (slot(0) !== exp_word(exp_life, 3'd6, 10'd10, 10'd1022)) begin
      tests_failed++;
      $display("FAIL move_W_wrap got=%h exp=%h", slot(0), exp_word(exp_life, 3'd6, 10'd10, 10'd1022));
    end
    tests_run++;
    if (slot(1) !== exp_word(exp_life, 3'd1, 10'd7, 10'd13)) begin
      tests_failed++;
      $display("FAIL move_NE got=%h exp=%h", slot(1), exp_word(exp_life, 3'd1, 10'd7, 10'd13));
    end
    tests_run++;
    if (slot(2) !== exp_word(exp_life, 3'd3, 10'd63, 10'd53)) begin
      tests_failed++;
      $display("FAIL move_SE_same_cycle got=%h exp=%h", slot(2), exp_word(exp_life, 3'd3, 10'd63, 10'd53));
    end
    tick();
    tests_run++;
    if (update_done !== 1'b0) begin tests_failed++; $display("FAIL done_one_cycle got=%b exp=0", update_done); end
    run_sweep(lat);
    tests_run++;
    if (slot(0)[15:6] !== 10'd1018 || slot(0)[25:16] !== 10'd10) begin
      tests_failed++;
      $display("FAIL move_W_second got x=%0d y=%0d exp x=1018 y=10", slot(0)[15:6], slot(0)[25:16]);
    end
  endtask

  task automatic test_delete_priority();
    int lat;
    do_reset();
    // Delete and spawn targeting the same free slot: the delete wins.
    bus.delete_shot  = 1'b1;
    bus.shot_address = 10'd0;
    spawn(10'd30, 10'd40, 3'd2);
    bus.delete_shot  = 1'b0;
    tests_run++;
    if (slot(0) !== '0 || active_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL del_vs_spawn got s0=%h cnt=%0d exp 0", slot(0), active_count);
    end
    spawn(10'd100, 10'd100, 3'd0);
    frame_tick = 1'b1;
    tick();
    frame_tick       = 1'b0;
    bus.delete_shot  = 1'b1;
    bus.shot_address = 10'd0;
    tick();
    bus.delete_shot  = 1'b0;
    lat = 0;
    while (!update_done && lat < 20) begin tick(); lat++; end
    tests_run++;
    if (!update_done) begin tests_failed++; $display("FAIL del_sweep_timeout got done=0 exp=1"); end
    tests_run++;
    if (slot(0) !== '0 || active_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL del_vs_update got s0=%h cnt=%0d exp 0", slot(0), active_count);
    end
  endtask

  task automatic test_overrun_reset();
    int pulses;
    do_reset();
    spawn(10'd10, 10'd20, 3'd2);
    frame_tick = 1'b1;
    tick();
    tick();
    frame_tick = 1'b0;
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (update_done) pulses++;
      tick();
    end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL overrun_one_done got=%0d exp=1", pulses); end
    tests_run++;
    if (overrun !== 1'b1 || slot(0)[15:6] !== 10'd14) begin
      tests_failed++;
      $display("FAIL overrun_sticky got ovr=%b x=%0d exp ovr=1 x=14", overrun, slot(0)[15:6]);
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    reset_n    = 1'b0;
    tick();
    tests_run++;
    if (shots !== '0 || overrun !== 1'b0 || active_count !== 2'd0 || update_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_sweep got shots=%h ovr=%b cnt=%0d done=%b", shots, overrun, active_count, update_done);
    end
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 8; i++) begin
      if (update_done) pulses++;
      tick();
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abandoned_sweep_done got=%0d exp=0", pulses); end
  endtask

  task automatic test_lifetime();
    int lat;
    int n_sweeps;
    logic exp_act;
    do_reset();
    spawn(10'd100, 10'd100, 3'd2);
`ifdef SHOT_LIFETIME_EN
    n_sweeps = 6;
`else
    n_sweeps = 10;
`endif
    for (int k = 1; k <= n_sweeps; k++) begin
      run_sweep(lat);
      tests_run++;
      if (lat === 0) begin tests_failed++; $display("FAIL life_sweep_timeout sweep=%0d", k); end
`ifdef SHOT_LIFETIME_EN
      exp_act = (k < 6);
`else
      exp_act = 1'b1;
`endif
      tests_run++;
      if (slot(0)[33] !== exp_act) begin
        tests_failed++;
        $display("FAIL life_active sweep=%0d got=%b exp=%b", k, slot(0)[33], exp_act);
      end
      tick();
    end
`ifdef SHOT_LIFETIME_EN
    tests_run++;
    if (slot(0) !== '0 || active_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL life_expired got s0=%h cnt=%0d exp 0", slot(0), active_count);
    end
`else
    tests_run++;
    if (slot(0) !== exp_word(3'd6, 3'd2, 10'd100, 10'd140)) begin
      tests_failed++;
      $display("FAIL life_static got=%h exp=%h", slot(0), exp_word(3'd6, 3'd2, 10'd100, 10'd140));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_fill_delete();
    test_motion();
    test_delete_priority();
    test_overrun_reset();
    test_lifetime();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shot_table.md
Name: shot_table

Overview:
Storage and motion stage for player shots, directly upstream of the collision controller.
- Holds MAX_SHOTS entity words and accepts new shots from the ship/fire logic.
- Advances every active shot once per frame.
- Clears entries when the collision controller pulses delete_shot.
- Drives the packed shots array the collision controller consumes.

Parameters:
MAX_SHOTS, 3, number of shot slots
ENTITY_SIZE, 34, bits per entity word
SHOT_SPEED, 4, pixels per frame along an axis for cardinal headings; diagonals use SHOT_SPEED-1 per axis
SHOT_LIFETIME, 6, frames before auto-expiry (1..7; used only with SHOT_LIFETIME_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse, start of frame update
spawn_valid  in  1  request a new shot
spawn_ready  out  1  slot free and FSM idle
spawn_x  in  10  initial x
spawn_y  in  10  initial y
spawn_heading  in  3  direction 0=N,1=NE,...,7=NW (clockwise)
delete_shot  in  1  one-cycle delete request from collision controller
shot_address  in  10  slot to delete
shots  out  MAX_SHOTS*ENTITY_SIZE  packed entity words, slot i at [i]
active_count  out  $clog2(MAX_SHOTS+1)  number of active slots
update_done  out  1  one-cycle pulse after sweep completes
overrun  out  1  sticky; frame_tick arrived while not IDLE

Behaviour:
Entity word fields:
- [33] active
- [32:30] life counter
- [28:26] heading
- [25:16] y
- [15:6] x
- [5:0] sprite id, constant 6'd2 for shots
- [29] reserved, 0

Reset (reset_n low at a clk edge):
- All entries 0; state IDLE.
- spawn_ready, update_done, overrun all 0; active_count 0.
- Reset mid-sweep abandons the sweep; no update_done is emitted.

FSM states:
- IDLE -> UPDATE on frame_tick; index cleared to 0.
- UPDATE processes slot[index] each cycle. If the slot is active:
  - x += vx, y += vy; plain 10-bit modular add.
  - Negative results wrap to a large value, which downstream out-of-bounds logic deletes.
- UPDATE -> DONE after index == MAX_SHOTS-1.
- DONE asserts update_done for exactly one cycle, then -> IDLE.
- Sweep latency: MAX_SHOTS+1 cycles from frame_tick to update_done.
- frame_tick outside IDLE is ignored and sets overrun until reset.

Spawn:
- spawn_ready = (state==IDLE) && any slot inactive. Combinational from registered state.
- A transfer occurs when spawn_valid && spawn_ready at an edge. The lowest-index inactive slot is written with active=1, life=SHOT_LIFETIME, the spawn fields and sprite id.
- The new entry is visible on shots the next cycle.
- frame_tick and a transfer in the same IDLE cycle: both happen; the new shot is moved in this sweep.

Delete:
- Clears active and zeroes the word the next cycle.
- shot_address >= MAX_SHOTS is ignored.
- Accepted in every state.
- Priority within a slot in one cycle: delete > sweep update > spawn.
- If delete targets the slot being spawned into, the delete wins and the spawn still counts as accepted.
- Deleting an inactive slot has no effect.

Other rules:
- active_count is registered and consistent with shots on the same cycle.
- Velocity table, with s = SHOT_SPEED and d = SHOT_SPEED-1:
  - N (0,-s), NE (+d,-d), E (+s,0), SE (+d,+d)
  - S (0,+s), SW (-d,+d), W (-s,0), NW (-d,-d)

Optional Feature:
SHOT_LIFETIME_EN
- Defined: during the sweep, each active slot decrements life. A slot whose life is 1 before the decrement is cleared instead of moved. A shot therefore survives exactly SHOT_LIFETIME sweeps.
- Undefined: the life field is written at spawn and never changes; shots expire only by delete_shot.

Decomposition:
Package asteroids_pkg holds:
- Field bit-position localparams: ACTIVE_BIT, LIFE_MSB/LSB, HEAD_MSB/LSB, Y_MSB/LSB, X_MSB/LSB, SPRITE_MSB/LSB
- SPRITE_SHOT = 6'd2
- typedef heading_t (3 bits)
- typedef screen_coord_t (10 bits)
- SCREEN_W = 320, SCREEN_H = 240

One sub-module, shot_velocity_lut: combinational heading -> signed 10-bit vx, vy; parameter SHOT_SPEED.

Test Plan:
1. Reset, then spawn (100,50,E) -> next cycle slot0 active, x=100, y=50, spawn_ready=1, active_count=1.
2. Spawn three shots, then hold spawn_valid -> spawn_ready=0 and no fourth write; delete_shot addr 1 -> slot1 cleared next cycle, spawn_ready=1, the next spawn lands in slot1.
3. Shot at (2,10,W), SHOT_SPEED=4, frame_tick -> after update_done x=10'd1022, y=10; shot (10,10,NE) -> x=13, y=7; update_done 4 cycles after tick.
4. delete_shot on slot0 in the same cycle the sweep updates slot0 -> slot0 inactive, all-zero after the sweep.
5. frame_tick repeated one cycle into a sweep -> overrun=1 and sticky; only one update_done; reset_n low mid-sweep -> all entries 0, no update_done.
6. With SHOT_LIFETIME_EN and SHOT_LIFETIME=6: spawn, issue 6 frame_ticks -> active after sweep 5, cleared during sweep 6; without the macro -> still active after 10 sweeps.
